// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between execute and a req/ack data bus.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t r_state, w_next;
  logic r_st, r_err;
  logic [2:0] r_f3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;
  logic w_is_ld, w_is_st, w_accept, w_bad_f3, w_mis, w_ill, w_timeout;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  assign w_is_ld   = opcode == 7'b0000011;
  assign w_is_st   = opcode == 7'b0100011;
  assign w_accept  = start && r_state == IDLE && (w_is_ld || w_is_st);
  assign w_bad_f3  = w_is_ld ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : funct3 > 3'b010;
  assign w_mis     = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign w_ill     = w_bad_f3 || w_mis;
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  assign w_byte = r_addr[1] ? (r_addr[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                            : (r_addr[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_ld   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_byte[7]}}, w_byte}
                : r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half} : mem_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? (w_ill ? RESP : REQ) : IDLE;
      REQ:     w_next = (mem_ack || w_timeout) ? RESP : REQ;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != IDLE;
    done      = r_state == RESP;
    err       = done && r_err;
    rdata     = r_rdata;
    mem_req   = r_state == REQ;
    mem_we    = mem_req && r_st;
    mem_addr  = {r_addr[31:2], 2'b00};
    mem_wdata = r_f3[1:0] == 2'b00 ? {4{r_wdata[7:0]}}
              : r_f3[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
    mem_be    = !mem_we ? 4'b0000
              : r_f3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0]
              : r_f3[1:0] == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_st    <= w_is_st;
      r_err   <= w_ill;
      r_f3    <= funct3;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_cnt   <= '0;
    end else if (r_state == REQ) begin
      // an ack in the final wait cycle still wins over the timeout
      if (mem_ack) begin
        if (!r_st) r_rdata <= w_ld;
      end else if (w_timeout) r_err <= 1'b1;
      else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
